impact_sram_access_sequencer: RTL and testbench
===============================================

// Module: impact_sram_access_sequencer
// PURPOSE
// - Upstream stage of user_proj_IMPACT_HEAD. Turns single-word read/write commands into the
//   timed SRAM control strobes the macro consumes: PreCharge, WL_enable, Data_In_Enable,
//   WriteEnable and ReadEnable. It also drives Byte_Select, Proj_Select and Data_In.
// - Captures Data_Out at the end of a read and returns it over a valid/ready response port.
// - Replaces hand-toggled io_in strobes with a deterministic, parameterised timing sequence.
// PARAMETERS
// - PRECHARGE_CYC  2  cycles PreCharge is held high (>=1)
// - WL_CYC         2  cycles WL_enable is held high with WriteEnable/ReadEnable (>=1)
// - SENSE_CYC      1  read-only cycles after WL, ReadEnable held, before capture (>=1)
// - DATA_W         8  data width
// PORTS
// - clk                  in   1       single clock
// - rst                  in   1       synchronous, active-high reset
// - cmd_valid            in   1       command offered
// - cmd_ready            out  1       high only in IDLE
// - cmd_write            in   1       1 = write, 0 = read
// - cmd_byte_sel         in   2       byte select for the access
// - cmd_proj_sel         in   2       project select for the access
// - cmd_wdata            in   DATA_W  write data
// - rsp_valid            out  1       read data available
// - rsp_ready            in   1       consumer accepts the read data
// - rsp_rdata            out  DATA_W  captured read data
// - sram_precharge       out  1       to PreCharge
// - sram_wl_enable       out  1       to WL_enable
// - sram_data_in_enable  out  1       to Data_In_Enable
// - sram_write_enable    out  1       to WriteEnable
// - sram_read_enable     out  1       to ReadEnable
// - sram_byte_select     out  2       to Byte_Select
// - sram_proj_select     out  2       to Proj_Select
// - sram_data_in         out  DATA_W  to Data_In
// - sram_data_out        in   DATA_W  from Data_Out
// - busy                 out  1       state != IDLE
// BEHAVIOUR
// - Reset (sync, rst high at posedge):
//   - state <= IDLE.
//   - All sram_* strobes, rsp_valid and busy are 0.
//   - sram_byte_select, sram_proj_select, sram_data_in and rsp_rdata are 0.
//   - Reset mid-operation aborts the access. Strobes are low in the cycle after the reset edge,
//     and no response is produced.
// - Strobes and SRAM buses are driven from flops, never from combinational decode.
// - Accept: at a posedge with cmd_valid && cmd_ready.
//   - Latch write/byte_sel/proj_sel/wdata onto the sram_* buses.
//   - The buses hold stable until the next accept.
// - FSM (cycle k counts from 1 = first cycle after the accept edge):
//   - IDLE: cmd_ready=1. Accept -> PRECHARGE.
//   - PRECHARGE: sram_precharge=1 for PRECHARGE_CYC cycles -> SETUP.
//   - SETUP: 1 cycle, all strobes low. For a write, sram_data_in_enable=1.
//   - WORDLINE: WL_CYC cycles, sram_wl_enable=1.
//     - Write: sram_write_enable=1, data_in_enable stays 1 -> RECOVER.
//     - Read: sram_read_enable=1 -> SENSE.
//   - SENSE (read only): SENSE_CYC cycles, sram_read_enable=1, wl_enable=0.
//     - rsp_rdata <= sram_data_out at the last SENSE edge -> RESP.
//   - RESP: rsp_valid=1. rsp_rdata is held stable until rsp_valid && rsp_ready, then -> IDLE.
//     No command is accepted in RESP.
//   - RECOVER (write only): 1 cycle, all strobes low -> IDLE.
// - Default latency:
//   - Read: rsp_valid first high at k=7. With rsp_ready=1 it is high 1 cycle; cmd_ready is high
//     at k=8.
//   - Write: RECOVER at k=6; cmd_ready is high at k=7.
// - Mutual exclusion: precharge is never high with wl_enable. write_enable and read_enable are
//   never both high.
// - Phase counter: width $clog2(max(PRECHARGE_CYC,WL_CYC,SENSE_CYC)+1).
//   - Loaded with N-1 on phase entry; the phase exits when the counter reaches 0.
// - cmd_valid while busy is ignored and not queued; the requester holds it until cmd_ready.
// - A parameter value of 0 is illegal. Elaboration fails via a generate-time check.
// STRUCTURE
// - Package impact_sram_pkg:
//   - state enum (IDLE, PRECHARGE, SETUP, WORDLINE, SENSE, RESP, RECOVER).
//   - default timing constants.
//   - DATA_W default.
// - Sub-module impact_phase_timer: loadable down-counter with a done flag, instanced once and
//   shared by all timed phases.
// TESTING
// 1. Reset: rst high for 2 cycles with cmd_valid=1 -> all strobes/rsp_valid/busy 0 and
//    cmd_ready=1 after release.
// 2. Default read: cmd_byte_sel=2'b01, proj_sel=2'b10, sram_data_out=8'hA5 during SENSE.
//    - precharge k1-2, wl+read_enable k4-5, read_enable k6.
//    - rsp_valid k7 with rsp_rdata=8'hA5.
// 3. Default write, wdata=8'h3C: precharge k1-2, data_in_enable k3-5, wl+write_enable k4-5,
//    sram_data_in=8'h3C throughout, cmd_ready at k7.
// 4. Backpressure: read with rsp_ready=0 for 5 cycles and a second cmd_valid pending.
//    - rsp_valid and rsp_rdata stay stable; cmd_ready stays 0.
//    - The second command is accepted the cycle after the rsp handshake.
// 5. Reset mid-operation: assert rst during WORDLINE of a write -> all strobes 0 next cycle,
//    no response, a clean read afterwards.
// 6. PRECHARGE_CYC=4, WL_CYC=3, SENSE_CYC=2 read:
//    - precharge high 4 cycles, wl high 3 cycles, read_enable high 5 cycles.
//    - rsp_valid at k=11.

Source files
------------

// File: rtl/impact_sram_pkg.sv
// Shared types and timing defaults for the IMPACT SRAM access sequencer.
// State encoding, default phase lengths and data width.
package impact_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    SETUP,
    WORDLINE,
    SENSE,
    RESP,
    RECOVER
  } state_t;

  localparam int DEF_PRECHARGE_CYC = 2;
  localparam int DEF_WL_CYC        = 2;
  localparam int DEF_SENSE_CYC     = 1;
  localparam int DEF_DATA_W        = 8;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/impact_sram_access_sequencer_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// done is high whenever the count has reached zero.
module impact_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/impact_sram_access_sequencer.sv
// Sequences single-word read/write commands into timed SRAM strobes
// and returns captured read data over a valid/ready response port.
module impact_sram_access_sequencer
  import impact_sram_pkg::*;
#(
  parameter int PRECHARGE_CYC = DEF_PRECHARGE_CYC,
  parameter int WL_CYC        = DEF_WL_CYC,
  parameter int SENSE_CYC     = DEF_SENSE_CYC,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_byte_sel,
  input  logic [1:0]        cmd_proj_sel,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_precharge,
  output logic              sram_wl_enable,
  output logic              sram_data_in_enable,
  output logic              sram_write_enable,
  output logic              sram_read_enable,
  output logic [1:0]        sram_byte_select,
  output logic [1:0]        sram_proj_select,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic              busy
);

  localparam int CW =
    $clog2(max3(PRECHARGE_CYC, WL_CYC, SENSE_CYC) + 1);
  localparam logic [CW-1:0] PRE_LD = CW'(PRECHARGE_CYC - 1);
  localparam logic [CW-1:0] WL_LD  = CW'(WL_CYC - 1);
  localparam logic [CW-1:0] SEN_LD = CW'(SENSE_CYC - 1);

  generate
    if (PRECHARGE_CYC < 1 || WL_CYC < 1 || SENSE_CYC < 1) begin : g_bad
      $error("impact_sram_access_sequencer: phase length must be >= 1");
    end
  endgenerate

  state_t        state;
  logic          wr_q;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  impact_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer is loaded on the edge that enters each timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      IDLE: begin
        tmr_load = cmd_valid;
        tmr_val  = PRE_LD;
      end
      SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = WL_LD;
      end
      WORDLINE: begin
        tmr_load = tmr_done && !wr_q;
        tmr_val  = SEN_LD;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      wr_q                <= 1'b0;
      sram_precharge      <= 1'b0;
      sram_wl_enable      <= 1'b0;
      sram_data_in_enable <= 1'b0;
      sram_write_enable   <= 1'b0;
      sram_read_enable    <= 1'b0;
      sram_byte_select    <= '0;
      sram_proj_select    <= '0;
      sram_data_in        <= '0;
      rsp_valid           <= 1'b0;
      rsp_rdata           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_q             <= cmd_write;
            sram_byte_select <= cmd_byte_sel;
            sram_proj_select <= cmd_proj_sel;
            sram_data_in     <= cmd_wdata;
            sram_precharge   <= 1'b1;
            state            <= PRECHARGE;
          end
        end
        PRECHARGE: begin
          if (tmr_done) begin
            sram_precharge      <= 1'b0;
            sram_data_in_enable <= wr_q;
            state               <= SETUP;
          end
        end
        SETUP: begin
          sram_wl_enable    <= 1'b1;
          sram_write_enable <= wr_q;
          sram_read_enable  <= !wr_q;
          state             <= WORDLINE;
        end
        WORDLINE: begin
          if (tmr_done) begin
            sram_wl_enable      <= 1'b0;
            sram_write_enable   <= 1'b0;
            sram_data_in_enable <= 1'b0;
            state               <= wr_q ? RECOVER : SENSE;
          end
        end
        SENSE: begin
          if (tmr_done) begin
            sram_read_enable <= 1'b0;
            rsp_rdata        <= sram_data_out;
            rsp_valid        <= 1'b1;
            state            <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_impact_sram_access_sequencer.sv
// Scoreboard bench for the SRAM access sequencer: default and
// stretched timing instances, expectations queued per cycle.
module tb_impact_sram_access_sequencer;

  typedef struct {
    logic [7:0]  ctl;
    logic [11:0] bus;
    logic [7:0]  rd;
    bit          cb;
    bit          cr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_write = 1'b0;
  logic [1:0] cmd_byte_sel = '0;
  logic [1:0] cmd_proj_sel = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cv0 = 1'b1, cv1 = 1'b1;
  logic       rr0 = 1'b1, rr1 = 1'b1;
  logic [7:0] do0 = '0, do1 = '0;

  logic       crdy0, rv0, pre0, wl0, die0, we0, re0, busy0;
  logic       crdy1, rv1, pre1, wl1, die1, we1, re1, busy1;
  logic [7:0] rd0, rd1, din0, din1;
  logic [1:0] bs0, bs1, ps0, ps1;
  logic [7:0] ob0, ob1;

  assign ob0 = {pre0, wl0, die0, we0, re0, crdy0, rv0, busy0};
  assign ob1 = {pre1, wl1, die1, we1, re1, crdy1, rv1, busy1};

  always #5 clk = ~clk;

  impact_sram_access_sequencer dut0 (
    .clk (clk), .rst (rst),
    .cmd_valid (cv0), .cmd_ready (crdy0),
    .cmd_write (cmd_write), .cmd_byte_sel (cmd_byte_sel),
    .cmd_proj_sel (cmd_proj_sel), .cmd_wdata (cmd_wdata),
    .rsp_valid (rv0), .rsp_ready (rr0), .rsp_rdata (rd0),
    .sram_precharge (pre0), .sram_wl_enable (wl0),
    .sram_data_in_enable (die0), .sram_write_enable (we0),
    .sram_read_enable (re0), .sram_byte_select (bs0),
    .sram_proj_select (ps0), .sram_data_in (din0),
    .sram_data_out (do0), .busy (busy0)
  );

  impact_sram_access_sequencer #(
    .PRECHARGE_CYC (4), .WL_CYC (3), .SENSE_CYC (2), .DATA_W (8)
  ) dut1 (
    .clk (clk), .rst (rst),
    .cmd_valid (cv1), .cmd_ready (crdy1),
    .cmd_write (cmd_write), .cmd_byte_sel (cmd_byte_sel),
    .cmd_proj_sel (cmd_proj_sel), .cmd_wdata (cmd_wdata),
    .rsp_valid (rv1), .rsp_ready (rr1), .rsp_rdata (rd1),
    .sram_precharge (pre1), .sram_wl_enable (wl1),
    .sram_data_in_enable (die1), .sram_write_enable (we1),
    .sram_read_enable (re1), .sram_byte_select (bs1),
    .sram_proj_select (ps1), .sram_data_in (din1),
    .sram_data_out (do1), .busy (busy1)
  );

  exp_t       q0[$], q1[$];
  logic [7:0] rq0[$], rq1[$];
  int         total = 0;
  int         bad = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Control vector {pre,wl,die,we,re,cmd_ready,rsp_valid,busy}
  // k cycles after the accept edge; k=0 is the idle accept cycle.
  function automatic logic [7:0] ev(int k, bit wr, int p, int w,
                                    int s);
    if (k == 0) return 8'b0000_0100;
    if (k <= p) return 8'b1000_0001;
    if (k == p + 1) return wr ? 8'b0010_0001 : 8'b0000_0001;
    if (k <= p + w + 1) return wr ? 8'b0111_0001 : 8'b0100_1001;
    if (wr) return (k == p + w + 2) ? 8'b0000_0001 : 8'b0000_0100;
    if (k <= p + w + 1 + s) return 8'b0000_1001;
    return 8'b0000_0011;
  endfunction

  function automatic void push(bit d, exp_t e);
    if (d) q1.push_back(e);
    else q0.push_back(e);
  endfunction

  function automatic exp_t mk(logic [7:0] c, logic [11:0] b, bit cb);
    exp_t e;
    e.ctl = c;
    e.bus = b;
    e.rd  = '0;
    e.cb  = cb;
    e.cr  = 1'b0;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e = mk(8'b0000_0100, 12'h000, 1'b1);
    e.cr = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("ctl0", 32'(ob0), 32'(e.ctl));
      if (e.cb) chk("bus0", 32'({bs0, ps0, din0}), 32'(e.bus));
      if (e.cr) chk("rdata0", 32'(rd0), 32'(e.rd));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("ctl1", 32'(ob1), 32'(e.ctl));
      if (e.cb) chk("bus1", 32'({bs1, ps1, din1}), 32'(e.bus));
      if (e.cr) chk("rdata1", 32'(rd1), 32'(e.rd));
    end
    if (rv0 === 1'b1) begin
      if (rq0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp0_unexpected act=%h exp=none", rd0);
      end else begin
        chk("rsp0", 32'(rd0), 32'(rq0[0]));
        if (rr0) void'(rq0.pop_front());
      end
    end
    if (rv1 === 1'b1) begin
      if (rq1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp1_unexpected act=%h exp=none", rd1);
      end else begin
        chk("rsp1", 32'(rd1), 32'(rq1[0]));
        if (rr1) void'(rq1.pop_front());
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      cv0 = 1'b0;
      cv1 = 1'b0;
      q0.push_back(mk(8'b0000_0100, 12'h000, 1'b0));
      q1.push_back(mk(8'b0000_0100, 12'h000, 1'b0));
    end
  endtask

  task automatic do_cmd(input bit d, input bit wr,
                        input logic [1:0] bs, input logic [1:0] ps,
                        input logic [7:0] wd, input logic [7:0] dv,
                        input int hold, input bit pend,
                        input int abort_k);
    int p, w, s, n;
    logic [7:0] dd;
    p = d ? 4 : 2;
    w = d ? 3 : 2;
    s = d ? 2 : 1;
    n = wr ? p + w + 2 : p + w + s + 2 + hold;
    @(posedge clk); #1;
    cmd_write    = wr;
    cmd_byte_sel = bs;
    cmd_proj_sel = ps;
    cmd_wdata    = wd;
    if (d) cv1 = 1'b1;
    else cv0 = 1'b1;
    if (!wr && abort_k == 0) begin
      if (d) rq1.push_back(dv);
      else rq0.push_back(dv);
    end
    push(d, mk(ev(0, wr, p, w, s), 12'h000, 1'b0));
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (d) cv1 = pend;
      else cv0 = pend;
      if (pend) begin
        cmd_byte_sel = ~bs;
        cmd_proj_sel = ~ps;
        cmd_wdata    = ~wd;
      end
      dd = (k >= p + w + 2 && k <= p + w + 1 + s) ? dv : ~dv;
      if (d) begin
        do1 = dd;
        rr1 = (k >= p + w + s + 2 + hold);
      end else begin
        do0 = dd;
        rr0 = (k >= p + w + s + 2 + hold);
      end
      push(d, mk(ev(k, wr, p, w, s), {bs, ps, wd}, 1'b1));
      if (k == abort_k) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cv0 = 1'b0;
        cv1 = 1'b0;
        push(d, rst_exp());
        return;
      end
    end
  endtask

  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // reset held two cycles with a command offered
    @(posedge clk); #1;
    q0.push_back(rst_exp());
    q1.push_back(rst_exp());
    @(posedge clk); #1;
    q0.push_back(rst_exp());
    q1.push_back(rst_exp());
    rst = 1'b0;
    cv0 = 1'b0;
    cv1 = 1'b0;
    idle(1);
    // default read and write
    do_cmd(0, 0, 2'b01, 2'b10, 8'h11, 8'hA5, 0, 0, 0);
    do_cmd(0, 1, 2'b10, 2'b01, 8'h3C, 8'h00, 0, 0, 0);
    idle(1);
    // backpressured read with a second command waiting
    do_cmd(0, 0, 2'b11, 2'b00, 8'h22, 8'hC3, 5, 1, 0);
    do_cmd(0, 0, 2'b00, 2'b11, 8'h44, 8'h96, 0, 0, 0);
    // reset during the wordline of a write, then a clean read
    do_cmd(0, 1, 2'b01, 2'b01, 8'hF0, 8'h00, 0, 0, 4);
    do_cmd(0, 0, 2'b10, 2'b10, 8'h55, 8'h0F, 0, 0, 0);
    idle(1);
    // stretched timing instance
    do_cmd(1, 0, 2'b01, 2'b11, 8'h77, 8'h5A, 1, 0, 0);
    do_cmd(1, 1, 2'b11, 2'b10, 8'hE1, 8'h00, 0, 0, 0);
    idle(2);
    @(negedge clk); #1;
    chk("rq0_left", 32'(rq0.size()), 32'd0);
    chk("rq1_left", 32'(rq1.size()), 32'd0);
    chk("q0_left", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
